// File: rtl/riscv_mdu_seq_if.sv
// Request/response bundle between the decoder (master) and the
// iterative multiply/divide unit (slave).
interface riscv_mdu_seq_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  start_i;
    logic [2:0]            op_i;
    logic [WORD_WIDTH-1:0] a_i;
    logic [WORD_WIDTH-1:0] b_i;
    logic                  kill_i;
    logic                  busy_o;
    logic                  valid_o;
    logic [WORD_WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, a_i, b_i, kill_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, kill_i,
        output busy_o, valid_o, result_o
    );
endinterface

// File: rtl/riscv_mdu_seq.sv
// Iterative RV32M multiply/divide unit. One shared 2W-bit working register
// serves both a shift-add multiplier and a restoring divider, stepped one
// bit per cycle for W cycles, followed by a sign/special-case fix cycle.
module riscv_mdu_seq #(
    parameter int WORD_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    riscv_mdu_seq_if.slave mdu
);
    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(W);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [W-1:0] WORD_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] WORD_ONES = {W{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [2:0]     op_q;
    logic [2*W-1:0] work;
    logic [W-1:0]   operand;
    logic [W-1:0]   a_orig;
    logic [W-1:0]   b_orig;
    logic           neg_q;
    logic           busy_q;
    logic           valid_q;
    logic [W-1:0]   result_q;

    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           start_sign;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] div_next;

    logic [2*W-1:0] prod;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic           div_zero;
    logic           overflow;
    logic [W-1:0]   fix_result;

    // Operand magnitudes and the result sign for the request on the bus.
    always_comb begin
        a_neg      = 1'b0;
        b_neg      = 1'b0;
        a_mag      = mdu.a_i;
        b_mag      = mdu.b_i;
        start_sign = 1'b0;
        if (mdu.op_i == OP_MULH || mdu.op_i == OP_MULHSU ||
            mdu.op_i == OP_DIV  || mdu.op_i == OP_REM)
            a_neg = mdu.a_i[W-1];
        if (mdu.op_i == OP_MULH || mdu.op_i == OP_DIV || mdu.op_i == OP_REM)
            b_neg = mdu.b_i[W-1];
        if (a_neg)
            a_mag = -mdu.a_i;
        if (b_neg)
            b_mag = -mdu.b_i;
        // Remainders take the dividend's sign; everything else is sign(a)^sign(b).
        start_sign = (mdu.op_i[2] && mdu.op_i[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // One iteration of the multiplier or divider on the shared register.
    always_comb begin
        mul_sum  = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, operand} : '0);
        mul_next = {mul_sum, work[W-1:1]};
        // The shifted partial remainder is W+1 bits wide; when it is at least
        // the divisor the difference always fits back into W bits.
        div_ge   = work[2*W-1:W-1] >= {1'b0, operand};
        div_diff = work[2*W-2:W-1] - operand;
        div_next = div_ge ? {div_diff, work[W-2:0], 1'b1} : {work[2*W-2:0], 1'b0};
    end

    // Sign correction and result selection, including the forced special cases.
    always_comb begin
        prod       = neg_q ? -work : work;
        quot       = neg_q ? -work[W-1:0] : work[W-1:0];
        rem        = neg_q ? -work[2*W-1:W] : work[2*W-1:W];
        div_zero   = (b_orig == '0);
        overflow   = (a_orig == WORD_MIN) && (b_orig == WORD_ONES);
        fix_result = '0;
        case (op_q)
            OP_MUL:                fix_result = prod[W-1:0];
            OP_MULH, OP_MULHSU,
            3'b011:                fix_result = prod[2*W-1:W];
            OP_DIV, 3'b101: begin
                if (div_zero)
                    fix_result = WORD_ONES;
                else if (op_q == OP_DIV && overflow)
                    fix_result = WORD_MIN;
                else
                    fix_result = quot;
            end
            default: begin
                if (div_zero)
                    fix_result = a_orig;
                else if (op_q == OP_REM && overflow)
                    fix_result = '0;
                else
                    fix_result = rem;
            end
        endcase
    end

    // Control FSM with registered busy/valid/result; kill wins over start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            op_q     <= '0;
            work     <= '0;
            operand  <= '0;
            a_orig   <= '0;
            b_orig   <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (mdu.kill_i) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (mdu.start_i) begin
                            state   <= CALC;
                            busy_q  <= 1'b1;
                            count   <= CW'(W - 1);
                            op_q    <= mdu.op_i;
                            a_orig  <= mdu.a_i;
                            b_orig  <= mdu.b_i;
                            neg_q   <= start_sign;
                            work    <= mdu.op_i[2] ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
                            operand <= mdu.op_i[2] ? b_mag : a_mag;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    CALC: begin
                        work <= op_q[2] ? div_next : mul_next;
                        if (count == '0)
                            state <= FIX;
                        else
                            count <= count - 1'b1;
                    end
                    FIX: begin
                        result_q <= fix_result;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign mdu.busy_o   = busy_q;
    assign mdu.valid_o  = valid_q;
    assign mdu.result_o = result_q;
endmodule

// File: tb/tb_riscv_mdu_seq.sv
// Self-checking bench for riscv_mdu_seq: directed RV32M cases, kill and
// asynchronous reset behaviour, random operations and back-to-back starts,
// all checked against an arithmetic reference model.
module tb_riscv_mdu_seq;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    riscv_mdu_seq_if #(.WORD_WIDTH(32)) bus ();

    riscv_mdu_seq #(.WORD_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (bus)
    );

    // Reference result computed with plain 64-bit and 32-bit arithmetic.
    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int     ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Issue one op and observe it for 40 edges after the accepting edge E0.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int valid_edge,
                          output int busy_fall, output int valid_cnt);
        res        = 32'd0;
        valid_edge = -1;
        busy_fall  = -1;
        valid_cnt  = 0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk);
        #1;
        if (!bus.busy_o) busy_fall = 0;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.op_i    = 3'($urandom);
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) begin
                valid_cnt++;
                if (valid_edge < 0) begin
                    valid_edge = e;
                    res        = bus.result_o;
                end
            end
            if (!bus.busy_o && busy_fall < 0) busy_fall = e;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.op_i    = 3'd0;
        bus.a_i     = 32'd0;
        bus.b_i     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy_o);
        end
        vectors++;
        if (bus.valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_valid: got %b, expected 0", bus.valid_o);
        end
        vectors++;
        if (bus.result_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_result: got %h, expected 00000000", bus.result_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  d_op [13] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] d_a  [13] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                   32'h80000000, 32'h80000000};
        logic [31:0] d_b  [13] = '{32'd6, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                   32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] d_x  [13] = '{32'd42, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,
                                   32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
                                   32'h80000000, 32'd0};
        logic [31:0] res;
        int ve, bf, vc;
        for (int i = 0; i < 13; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], res, ve, bf, vc);
            vectors++;
            if (res !== d_x[i]) begin
                miscompares++;
                $display("[TB] FAIL directed_result[%0d]: got %h, expected %h", i, res, d_x[i]);
            end
            vectors++;
            if (ve != 33) begin
                miscompares++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d, expected 33", i, ve);
            end
            // busy rises at E0 and stays high through E32, dropping at E33.
            vectors++;
            if (bf != 33) begin
                miscompares++;
                $display("[TB] FAIL directed_busy_fall[%0d]: got %0d, expected 33", i, bf);
            end
            vectors++;
            if (vc != 1) begin
                miscompares++;
                $display("[TB] FAIL directed_valid_count[%0d]: got %0d, expected 1", i, vc);
            end
        end
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int ve, bf, vc, late_valids;
        run_op(3'd0, 32'd7, 32'd6, res, ve, bf, vc);
        vectors++;
        if (res !== 32'd42) begin
            miscompares++;
            $display("[TB] FAIL kill_setup_result: got %h, expected 0000002a", res);
        end
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 3'd5;
        bus.a_i     = 32'd1000;
        bus.b_i     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.kill_i = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL kill_busy: got %b, expected 0", bus.busy_o);
        end
        vectors++;
        if (bus.result_o !== 32'd42) begin
            miscompares++;
            $display("[TB] FAIL kill_result_hold: got %h, expected 0000002a", bus.result_o);
        end
        @(negedge clk);
        bus.kill_i  = 1'b0;
        late_valids = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) late_valids++;
        end
        vectors++;
        if (late_valids != 0) begin
            miscompares++;
            $display("[TB] FAIL kill_no_valid: got %0d pulses, expected 0", late_valids);
        end
        vectors++;
        if (bus.result_o !== 32'd42) begin
            miscompares++;
            $display("[TB] FAIL kill_result_final: got %h, expected 0000002a", bus.result_o);
        end
    endtask

    task automatic test_async_reset();
        int late_valids;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 3'd0;
        bus.a_i     = 32'd3;
        bus.b_i     = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_rst_busy: got %b, expected 0", bus.busy_o);
        end
        vectors++;
        if (bus.valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_rst_valid: got %b, expected 0", bus.valid_o);
        end
        vectors++;
        if (bus.result_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL async_rst_result: got %h, expected 00000000", bus.result_o);
        end
        #1;
        rst = 1'b0;
        late_valids = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) late_valids++;
        end
        vectors++;
        if (late_valids != 0) begin
            miscompares++;
            $display("[TB] FAIL async_rst_no_valid: got %0d pulses, expected 0", late_valids);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, exp;
        int ve, bf, vc;
        for (int i = 0; i < 48; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 20);
                2:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd1;
                3:       b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            exp = ref_mdu(op, a, b);
            run_op(op, a, b, res, ve, bf, vc);
            vectors++;
            if (res !== exp || ve != 33 || vc != 1) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got %h at edge %0d (%0d pulses), expected %h at edge 33 (1 pulse)",
                         i, op, a, b, res, ve, vc, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op_at [102];
        logic [31:0] a_at  [102];
        logic [31:0] b_at  [102];
        logic        exp_valid;
        logic [31:0] exp;
        int          pulses;
        pulses = 0;
        for (int e = 0; e < 102; e++) begin
            @(negedge clk);
            bus.start_i = 1'b1;
            op_at[e]    = 3'($urandom_range(0, 7));
            a_at[e]     = $urandom;
            b_at[e]     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            bus.op_i    = op_at[e];
            bus.a_i     = a_at[e];
            bus.b_i     = b_at[e];
            @(posedge clk);
            #1;
            // Ops are taken at E0, E34 and E68, so results land at E33, E67, E101.
            exp_valid = (e == 33 || e == 67 || e == 101);
            if (bus.valid_o) pulses++;
            vectors++;
            if (bus.valid_o !== exp_valid) begin
                miscompares++;
                $display("[TB] FAIL b2b_valid[edge %0d]: got %b, expected %b", e, bus.valid_o, exp_valid);
            end
            if (exp_valid) begin
                exp = ref_mdu(op_at[e-33], a_at[e-33], b_at[e-33]);
                vectors++;
                if (bus.result_o !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_result[edge %0d]: got %h, expected %h", e, bus.result_o, exp);
                end
            end
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("[TB] FAIL b2b_pulse_count: got %0d, expected 3", pulses);
        end
        vectors++;
        if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_idle_after: got busy=%b valid=%b, expected busy=0 valid=0", bus.busy_o, bus.valid_o);
        end
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        test_reset();
        test_directed();
        test_kill();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end
endmodule
